// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: ID/EX/MEM status in, pipeline-control enables and status out.
// master = pipeline side, slave = hazard unit.
interface hazard_unit_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  localparam int unsigned REG_W = 5;

  logic               id_valid;
  logic [REG_W-1:0]   id_rs1;
  logic [REG_W-1:0]   id_rs2;
  logic               id_rs1_used;
  logic               id_rs2_used;
  logic [REG_W-1:0]   id_rd;
  logic               id_mem_read;
  logic               id_reg_write;
  logic               ex_branch_taken;
  logic               dmem_req;
  logic               dmem_ready;

  logic               stall;
  logic               pc_write;
  logic               if_id_write;
  logic               if_id_flush;
  logic               pipe_hold;
  logic               bus_err;
  logic [CNT_WIDTH-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_mem_read, id_reg_write, ex_branch_taken, dmem_req, dmem_ready,
    input  stall, pc_write, if_id_write, if_id_flush, pipe_hold, bus_err, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_mem_read, id_reg_write, ex_branch_taken, dmem_req, dmem_ready,
    output stall, pc_write, if_id_write, if_id_flush, pipe_hold, bus_err, stall_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, data-memory freeze with timeout watchdog,
// branch flush priority and a saturating stall-cycle counter.
module hazard_unit #(
  parameter int unsigned DMEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input logic          clk,
  input logic          rst_n,
  hazard_unit_if.slave hz
);
  localparam int unsigned WAIT_W = $clog2(DMEM_TIMEOUT);
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t               state;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 bus_err_q;
  logic                 ex_ld_vld;
  logic [REG_W-1:0]     ex_ld_rd;
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  logic freeze;
  logic flush;
  logic load_use;

  // Hazard detection and priority: freeze > flush > load_use.
  always_comb begin
    freeze   = (state == MEM_WAIT && !hz.dmem_ready) ||
               (state == RUN && hz.dmem_req && !hz.dmem_ready) ||
               (state == ERROR);
    // Flush is masked under reset so the reset output values hold regardless of EX.
    flush    = !freeze && hz.ex_branch_taken && rst_n;
    load_use = !freeze && !hz.ex_branch_taken && ex_ld_vld && hz.id_valid &&
               ((hz.id_rs1_used && (hz.id_rs1 == ex_ld_rd)) ||
                (hz.id_rs2_used && (hz.id_rs2 == ex_ld_rd)));

    hz.stall       = 1'b0;
    hz.pc_write    = 1'b1;
    hz.if_id_write = 1'b1;
    hz.if_id_flush = 1'b0;
    hz.pipe_hold   = 1'b0;
    if (freeze) begin
      hz.pipe_hold   = 1'b1;
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
    end else if (flush) begin
      hz.if_id_flush = 1'b1;
      hz.stall       = 1'b1;
    end else if (load_use) begin
      hz.stall       = 1'b1;
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
    end
  end

  // Data-memory wait FSM with watchdog; ERROR is terminal until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hz.dmem_req && !hz.dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (hz.dmem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_W'(DMEM_TIMEOUT - 1)) begin
            state     <= ERROR;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ERROR:   state <= ERROR;
        default: state <= RUN;
      endcase
    end
  end

  // Tracks whether EX holds a load with a nonzero destination; a stalled/flushed ID becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ld_vld <= 1'b0;
      ex_ld_rd  <= '0;
    end else if (!hz.pipe_hold) begin
      ex_ld_vld <= hz.id_valid && hz.id_mem_read && hz.id_reg_write &&
                   (hz.id_rd != '0) && !hz.stall && !hz.if_id_flush;
      ex_ld_rd  <= hz.id_rd;
    end
  end

  // Saturating count of cycles lost to stalls or freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if ((hz.stall || hz.pipe_hold) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign hz.bus_err   = bus_err_q;
  assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed plus randomized bench for hazard_unit against a cycle-level behavioural model.
module tb_hazard_unit;
  localparam int unsigned T  = 16;
  localparam int unsigned CW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_WIDTH(CW)) hz();
  hazard_unit #(.DMEM_TIMEOUT(T), .CNT_WIDTH(CW)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what sits in EX, how long memory has been stuck, error flag, stall count.
  bit          m_ld;
  logic [4:0]  m_rd;
  int          m_stuck;
  bit          m_err;
  logic [CW-1:0] m_cnt;
  bit          e_stall, e_freeze;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit mr, input bit rw, input bit br,
                        input bit req, input bit rdy);
    hz.id_valid = v;          hz.id_rs1 = 5'(rs1);      hz.id_rs2 = 5'(rs2);
    hz.id_rs1_used = u1;      hz.id_rs2_used = u2;      hz.id_rd = 5'(rd);
    hz.id_mem_read = mr;      hz.id_reg_write = rw;     hz.ex_branch_taken = br;
    hz.dmem_req = req;        hz.dmem_ready = rdy;
  endtask

  // Mid-cycle: derive expected outputs from the rules and compare.
  task automatic settle(input string tag);
    bit br, lu, hit;
    #4;
    if (!rst_n) begin
      m_ld = 0; m_stuck = 0; m_err = 0; m_cnt = '0;
    end
    e_freeze = m_err || (!hz.dmem_ready && (hz.dmem_req || m_stuck > 0));
    br  = !e_freeze && hz.ex_branch_taken && rst_n;
    hit = (hz.id_rs1_used && hz.id_rs1 == m_rd) || (hz.id_rs2_used && hz.id_rs2 == m_rd);
    lu  = !e_freeze && !hz.ex_branch_taken && m_ld && hz.id_valid && hit;
    e_stall = br || lu;
    chk({tag, ".stall"},       CW'(hz.stall),       CW'(e_stall));
    chk({tag, ".pc_write"},    CW'(hz.pc_write),    CW'(!e_freeze && !lu));
    chk({tag, ".if_id_write"}, CW'(hz.if_id_write), CW'(!e_freeze && !lu));
    chk({tag, ".if_id_flush"}, CW'(hz.if_id_flush), CW'(br));
    chk({tag, ".pipe_hold"},   CW'(hz.pipe_hold),   CW'(e_freeze));
    chk({tag, ".bus_err"},     CW'(hz.bus_err),     CW'(m_err));
    chk({tag, ".stall_cnt"},   hz.stall_cnt,        m_cnt);
  endtask

  // Commit this cycle's effect to the model, then move to just after the next edge.
  task automatic adv();
    if (rst_n) begin
      if (!e_freeze) begin
        m_ld = hz.id_valid && hz.id_mem_read && hz.id_reg_write && hz.id_rd != 0 && !e_stall;
        m_rd = hz.id_rd;
      end
      if ((e_stall || e_freeze) && m_cnt != '1) m_cnt = m_cnt + 1;
      if (e_freeze && !m_err) begin
        m_stuck++;
        if (m_stuck == T + 1) m_err = 1;
      end else if (!e_freeze) begin
        m_stuck = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag);
    settle(tag);
    adv();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    do_reset();

    // lw x5 then add x6,x5,x1: one stall cycle
    set_in(1, 0, 0, 1, 0, 5, 1, 1, 0, 0, 1); step("t1_lw");
    set_in(1, 5, 1, 1, 1, 6, 0, 1, 0, 0, 1); settle("t1_use");
    chk("t1_use_stall", CW'(hz.stall), 1);
    chk("t1_use_pcw", CW'(hz.pc_write), 0);
    adv();
    settle("t1_after");
    chk("t1_after_stall", CW'(hz.stall), 0);
    chk("t1_after_cnt", hz.stall_cnt, 1);
    adv();

    // lw x0 + reader of x0; lw x5 + non-reader
    set_in(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1); step("t2_lw0");
    set_in(1, 0, 0, 1, 1, 7, 0, 1, 0, 0, 1); settle("t2_rd0");
    chk("t2_x0_stall", CW'(hz.stall), 0);
    adv();
    set_in(1, 0, 0, 1, 0, 5, 1, 1, 0, 0, 1); step("t2_lw5");
    set_in(1, 5, 2, 0, 1, 8, 0, 1, 0, 0, 1); settle("t2_unused");
    chk("t2_unused_stall", CW'(hz.stall), 0);
    adv();

    // Memory wait for 3 cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); settle("t3_wait");
      chk("t3_hold", CW'(hz.pipe_hold), 1);
      chk("t3_stall", CW'(hz.stall), 0);
      adv();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); settle("t3_ready");
    chk("t3_ready_hold", CW'(hz.pipe_hold), 0);
    adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); settle("t3_run");
    chk("t3_cnt", hz.stall_cnt, 3);
    adv();

    // Branch concurrent with load-use: flush wins, no duplicate stall
    set_in(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1); step("t4_lw");
    set_in(1, 7, 0, 1, 0, 9, 0, 1, 1, 0, 1); settle("t4_br");
    chk("t4_flush", CW'(hz.if_id_flush), 1);
    chk("t4_stall", CW'(hz.stall), 1);
    chk("t4_pcw", CW'(hz.pc_write), 1);
    adv();
    set_in(1, 7, 0, 1, 0, 9, 0, 1, 0, 0, 1); settle("t4_next");
    chk("t4_next_stall", CW'(hz.stall), 0);
    adv();

    // Timeout: entry cycle plus 16 MEM_WAIT cycles, then sticky error
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < int'(T) + 1; i++) begin
      settle("t5_wait");
      chk("t5_no_err_yet", CW'(hz.bus_err), 0);
      adv();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      settle("t5_err");
      chk("t5_bus_err", CW'(hz.bus_err), 1);
      chk("t5_hold", CW'(hz.pipe_hold), 1);
      adv();
    end

    // Reset during MEM_WAIT with dmem_req low
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step("t6_enter");
    step("t6_w1");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    settle("t6_rst");
    chk("t6_hold", CW'(hz.pipe_hold), 0);
    chk("t6_err", CW'(hz.bus_err), 0);
    chk("t6_cnt", hz.stall_cnt, 0);
    adv();
    rst_n = 1'b1;
    settle("t6_run");
    chk("t6_run_hold", CW'(hz.pipe_hold), 0);
    adv();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      bit req;
      req = ($urandom_range(0, 99) < 30);
      set_in($urandom_range(0, 99) < 80, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 75,
             $urandom_range(0, 99) < 10, req, $urandom_range(0, 99) < 55);
      rst_n = ($urandom_range(0, 199) != 0);
      step("rnd");
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
